// File: rtl/multicycle_path_sequencer.sv
// multicycle_path_sequencer: round-robin arbitration of a shared launch/capture
// register pair. The selected operand is launched, then the path is held quiet
// for MCP_CYCLES cycles before the result is captured and returned to the owner.
module multicycle_path_sequencer #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MCP_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      launch_en,
  output logic [DATA_W-1:0]         launch_data,
  output logic                      capture_en,
  input  logic [DATA_W-1:0]         result_in,
  output logic [DATA_W-1:0]         result_out,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MCP_CYCLES > 1) ? $clog2(MCP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MCP_CYCLES - 1);
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  if (MCP_CYCLES < 1) begin : g_mcp_check
    $error("multicycle_path_sequencer: MCP_CYCLES must be >= 1");
  end

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("multicycle_path_sequencer: NUM_REQ must be in 2..8");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   launch_data_q, launch_data_d;
  logic [DATA_W-1:0]   result_out_q, result_out_d;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    scan_idx;

  // Round-robin pick: first set req bit scanning upward from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (scan_sum >= NUM_REQ_EXT) begin
        scan_sum = scan_sum - NUM_REQ_EXT;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic; requests and operands are only looked at while idle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    launch_data_d = launch_data_q;
    result_out_d  = result_out_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d       = win_idx;
          launch_data_d = req_data[int'(win_idx)*DATA_W +: DATA_W];
          rr_ptr_d      = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
          state_d       = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        result_out_d = result_in;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      launch_data_q <= '0;
      result_out_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      launch_data_q <= launch_data_d;
      result_out_q  <= result_out_d;
    end
  end

  // Moore outputs decoded from the registered state and owner.
  always_comb begin
    gnt        = '0;
    done       = '0;
    launch_en  = 1'b0;
    capture_en = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_LAUNCH: begin
        gnt       = NUM_REQ'(1) << owner_q;
        launch_en = 1'b1;
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
      end
      ST_DONE: begin
        done = NUM_REQ'(1) << owner_q;
      end
      default: begin
      end
    endcase
  end

  assign launch_data = launch_data_q;
  assign result_out  = result_out_q;

endmodule

// File: tb/tb_multicycle_path_sequencer.sv
// Testbench for multicycle_path_sequencer: directed scenarios plus random
// traffic compared against a transaction-timeline reference model.
module tb_multicycle_path_sequencer;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int MCP     = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        launch_en;
  logic [7:0]  launch_data;
  logic        capture_en;
  logic [7:0]  result_in;
  logic [7:0]  result_out;
  logic [3:0]  done;
  logic        busy;

  logic        m1_rst_n;
  logic [3:0]  m1_req;
  logic [31:0] m1_req_data;
  logic [3:0]  m1_gnt;
  logic        m1_launch_en;
  logic [7:0]  m1_launch_data;
  logic        m1_capture_en;
  logic [7:0]  m1_result_in;
  logic [7:0]  m1_result_out;
  logic [3:0]  m1_done;
  logic        m1_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: phase counts cycles since launch, -1 when idle
  int         m_phase = -1;
  int         m_ptr   = 0;
  int         m_owner = 0;
  logic [7:0] m_ldata = '0;
  logic [7:0] m_res   = '0;

  logic [3:0]  pend     = '0;
  logic [3:0]  pulse    = '0;
  logic [3:0]  keep     = '0;
  logic [31:0] data_bus = '0;
  logic [7:0]  res_val  = '0;
  int          g_idx[$];
  int          g_cyc[$];

  multicycle_path_sequencer #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MCP_CYCLES(MCP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .launch_en(launch_en), .launch_data(launch_data), .capture_en(capture_en),
    .result_in(result_in), .result_out(result_out), .done(done), .busy(busy)
  );

  multicycle_path_sequencer #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MCP_CYCLES(1)) dut_m1 (
    .clk(clk), .rst_n(m1_rst_n), .req(m1_req), .req_data(m1_req_data), .gnt(m1_gnt),
    .launch_en(m1_launch_en), .launch_data(m1_launch_data), .capture_en(m1_capture_en),
    .result_in(m1_result_in), .result_out(m1_result_out), .done(m1_done), .busy(m1_busy)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelUpdate();
    if (!rst_n) begin
      m_phase = -1;
      m_ptr   = 0;
      m_owner = 0;
      m_ldata = '0;
      m_res   = '0;
    end else if (m_phase < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (m_phase < 0 && req[c]) begin
          m_owner = c;
          m_ldata = req_data[c*DATA_W +: DATA_W];
          m_ptr   = (c + 1) % NUM_REQ;
          m_phase = 0;
        end
      end
    end else begin
      if (m_phase == MCP + 1) m_res = result_in;
      m_phase = (m_phase == MCP + 2) ? -1 : m_phase + 1;
    end
  endtask

  task automatic checkModel();
    logic [3:0] e_gnt;
    logic [3:0] e_done;
    e_gnt  = '0;
    e_done = '0;
    if (m_phase == 0) e_gnt[m_owner] = 1'b1;
    if (m_phase == MCP + 2) e_done[m_owner] = 1'b1;
    checkOutput("gnt", 32'(gnt), 32'(e_gnt));
    checkOutput("launch_en", 32'(launch_en), 32'(m_phase == 0));
    checkOutput("launch_data", 32'(launch_data), 32'(m_ldata));
    checkOutput("capture_en", 32'(capture_en), 32'(m_phase == MCP + 1));
    checkOutput("result_out", 32'(result_out), 32'(m_res));
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("busy", 32'(busy), 32'(m_phase >= 0));
  endtask

  // drive one cycle of inputs, advance the model at the edge, check at negedge
  task automatic applyStimulus(input logic rstv);
    rst_n     = rstv;
    req       = pend | pulse;
    req_data  = data_bus;
    result_in = res_val;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    cyc++;
    checkModel();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        g_idx.push_back(k);
        g_cyc.push_back(cyc);
      end
    end
    if (m_phase == 0 && !keep[m_owner]) pend[m_owner] = 1'b0;
  endtask

  initial begin
    int n2;
    int cap_at;
    int done_at;
    logic [7:0] m1_res_seen;
    rst_n = 1'b0; req = '0; req_data = '0; result_in = '0;
    m1_rst_n = 1'b0; m1_req = '0; m1_req_data = '0; m1_result_in = '0;
    @(negedge clk);

    // reset state
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_result", 32'(result_out), 0);

    // single transaction latency and data path
    pend = 4'b0001; data_bus = 32'h0000_00A5; res_val = 8'h5A;
    applyStimulus(1'b1);
    checkOutput("p1_gnt", 32'(gnt), 32'h1);
    checkOutput("p1_ldata", 32'(launch_data), 32'hA5);
    repeat (4) applyStimulus(1'b1);
    checkOutput("p1_capture", 32'(capture_en), 1);
    applyStimulus(1'b1);
    checkOutput("p1_done", 32'(done), 32'h1);
    checkOutput("p1_result", 32'(result_out), 32'h5A);
    applyStimulus(1'b1);
    checkOutput("p1_busy", 32'(busy), 0);

    // all four requesting: grant order 0..3, seven cycles apart
    applyStimulus(1'b0);
    g_idx.delete(); g_cyc.delete(); cyc = 0;
    pend = 4'b1111; data_bus = 32'h4433_2211;
    repeat (30) applyStimulus(1'b1);
    checkOutput("p2_count", 32'(g_idx.size()), 4);
    for (int k = 0; k < 4 && k < g_idx.size(); k++) begin
      checkOutput($sformatf("p2_order%0d", k), 32'(g_idx[k]), 32'(k));
      if (k > 0) checkOutput($sformatf("p2_gap%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 7);
    end

    // req1 and req3 held continuously alternate
    applyStimulus(1'b0);
    g_idx.delete(); g_cyc.delete(); cyc = 0;
    pend = 4'b1010; keep = 4'b1010;
    repeat (28) applyStimulus(1'b1);
    checkOutput("p3_count", 32'(g_idx.size()), 4);
    for (int k = 0; k < 4 && k < g_idx.size(); k++) begin
      checkOutput($sformatf("p3_order%0d", k), 32'(g_idx[k]), (k % 2 == 0) ? 1 : 3);
    end
    keep = '0; pend = '0;

    // reset in the middle of requester 2's wait aborts without done
    applyStimulus(1'b0);
    pend = 4'b0100; keep = 4'b0100;
    repeat (3) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("p4_busy", 32'(busy), 0);
    checkOutput("p4_done", 32'(done), 0);
    checkOutput("p4_gnt", 32'(gnt), 0);
    checkOutput("p4_ldata", 32'(launch_data), 0);
    keep = '0;
    applyStimulus(1'b1);
    checkOutput("p4_regrant", 32'(gnt), 32'h4);
    repeat (8) applyStimulus(1'b1);

    // a pulse during another owner's wait is never granted
    applyStimulus(1'b0);
    g_idx.delete(); g_cyc.delete();
    pend = 4'b0001;
    repeat (2) applyStimulus(1'b1);
    pulse = 4'b0100;
    applyStimulus(1'b1);
    pulse = '0;
    repeat (15) applyStimulus(1'b1);
    n2 = 0;
    foreach (g_idx[k]) if (g_idx[k] == 2) n2++;
    checkOutput("p6_gnt2", 32'(n2), 0);
    checkOutput("p6_grants", 32'(g_idx.size()), 1);
    checkOutput("p6_idle", 32'(busy), 0);

    // random traffic against the model
    applyStimulus(1'b0);
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(7) == 0) pend[i] = 1'b1;
      end
      pulse    = (m_phase >= 0 && $urandom_range(15) == 0) ? (~pend & 4'($urandom)) : 4'b0000;
      data_bus = $urandom;
      res_val  = 8'($urandom);
      applyStimulus($urandom_range(149) != 0);
    end
    pend = '0; pulse = '0;
    applyStimulus(1'b0);

    // MCP_CYCLES=1 instance: capture at T+3, done at T+4
    m1_req_data = 32'h0000_003C; m1_result_in = 8'hC3;
    @(negedge clk);
    m1_rst_n = 1'b1;
    m1_req   = 4'b0001;
    @(posedge clk);
    cap_at = -1; done_at = -1; m1_res_seen = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) m1_req = '0;
      if (m1_capture_en && cap_at < 0) cap_at = k;
      if (m1_done != 0 && done_at < 0) begin
        done_at = k;
        m1_res_seen = m1_result_out;
      end
    end
    checkOutput("p5_capture_at", 32'(cap_at), 3);
    checkOutput("p5_done_at", 32'(done_at), 4);
    checkOutput("p5_result", 32'(m1_res_seen), 32'hC3);
    checkOutput("p5_idle", 32'(m1_busy | m1_launch_en | (|m1_gnt) | (m1_launch_data != 8'h3C)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
